// File: rtl/oht2bin_pkg.sv
// Shared types and helpers for the pipelined one-hot to binary encoder tree.
// Optional multi-hot error tracking is enabled by OHT2BIN_PIPE_TREE_ERR_EN.
package oht2bin_pkg;

  localparam int unsigned SPLIT_MAX = 64;
  localparam int unsigned ENC_W     = 6;
  localparam int unsigned IDX_MAX   = 32;

  // Per-node record carried between tree levels
  typedef struct packed {
    logic               any;
    logic               err;
    logic [IDX_MAX-1:0] idx;
  } oht2bin_node_t;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [ENC_W-1:0] enc_lowest(input logic [SPLIT_MAX-1:0] v);
    logic [ENC_W-1:0] r;
    r = '0;
    for (int i = int'(SPLIT_MAX) - 1; i >= 0; i--) begin
      if (v[i]) r = ENC_W'(i);
    end
    return r;
  endfunction

  function automatic logic is_multi(input logic [SPLIT_MAX-1:0] v);
    return (v & (v - SPLIT_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/oht2bin_pipe_stage.sv
// One tree level: merges SPLIT child nodes into one parent node, then a valid/ready register slice.
// Carries an err flag per node when OHT2BIN_PIPE_TREE_ERR_EN is defined.
module oht2bin_pipe_stage
  import oht2bin_pkg::*;
#(
  parameter int unsigned NODES_IN = 2,
  parameter int unsigned SPLIT    = 2,
  parameter int unsigned IDX_W    = 0
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              up_vld,
  input  logic [NODES_IN-1:0]                               up_any,
  input  logic [NODES_IN*((IDX_W == 0) ? 1 : IDX_W)-1:0]    up_idx,
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
  input  logic [NODES_IN-1:0]                               up_err,
  output logic [NODES_IN/SPLIT-1:0]                         dn_err,
`endif
  input  logic                                              dn_rdy,
  output logic                                              dn_vld,
  output logic [NODES_IN/SPLIT-1:0]                         dn_any,
  output logic [(NODES_IN/SPLIT)*(IDX_W+$clog2(SPLIT))-1:0] dn_idx
);

  localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
  localparam int unsigned NODES_OUT = NODES_IN / SPLIT;
  localparam int unsigned IW_IN     = (IDX_W == 0) ? 1 : IDX_W;
  localparam int unsigned OW        = IDX_W + SPLIT_LOG;

  logic                    load_c;
  logic [NODES_OUT-1:0]    any_c;
  logic [NODES_OUT*OW-1:0] idx_c;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
  logic [NODES_OUT-1:0]    err_c;
`endif

  assign load_c = !dn_vld || dn_rdy;

  // Leaf level has no child index bits, so only the enc bits survive there
  always_comb begin : merge
    logic [SPLIT-1:0]     ch;
    logic [IW_IN-1:0]     low;
    logic [SPLIT_LOG-1:0] enc;
    any_c = '0;
    idx_c = '0;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
    err_c = '0;
`endif
    ch  = '0;
    low = '0;
    enc = '0;
    for (int unsigned n = 0; n < NODES_OUT; n++) begin
      ch  = up_any[n*SPLIT +: SPLIT];
      low = '0;
      for (int unsigned c = 0; c < SPLIT; c++) begin
        if (ch[c]) low = low | up_idx[(n*SPLIT+c)*IW_IN +: IW_IN];
      end
      enc                = SPLIT_LOG'(enc_lowest(SPLIT_MAX'(ch)));
      any_c[n]           = |ch;
      idx_c[n*OW +: OW]  = (IDX_W == 0) ? OW'(enc) : OW'({enc, low});
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      err_c[n] = (|up_err[n*SPLIT +: SPLIT]) | is_multi(SPLIT_MAX'(ch));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
      dn_any <= '0;
      dn_idx <= '0;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      dn_err <= '0;
`endif
    end else if (load_c) begin
      dn_vld <= up_vld;
      dn_any <= any_c;
      dn_idx <= idx_c;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      dn_err <= err_c;
`endif
    end
  end

endmodule

// File: rtl/oht2bin_pipe_tree.sv
// Pipelined SPLIT-ary one-hot to binary encoder, one register stage per tree level.
// Define OHT2BIN_PIPE_TREE_ERR_EN to flag multi-hot inputs on m_err (tied 0 otherwise).
module oht2bin_pipe_tree #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPLIT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_vld,
  output logic                     s_rdy,
  input  logic [WIDTH-1:0]         s_oht,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic [$clog2(WIDTH)-1:0] m_bin,
  output logic                     m_any,
  output logic                     m_err
);

  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
  localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
  localparam int unsigned LEVELS    = WIDTH_LOG / SPLIT_LOG;

  logic [LEVELS-1:0] stage_vld;
  logic [LEVELS:0]   rdy;

  // Ready ripples back from m_rdy; an empty stage is always ready
  always_comb begin
    rdy         = '0;
    rdy[LEVELS] = m_rdy;
    for (int k = int'(LEVELS) - 1; k >= 0; k--) begin
      rdy[k] = !stage_vld[k] || rdy[k+1];
    end
  end

  assign s_rdy = rdy[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NIN   = WIDTH >> (k * SPLIT_LOG);
    localparam int unsigned NOUT  = NIN / SPLIT;
    localparam int unsigned IW    = k * SPLIT_LOG;
    localparam int unsigned IW_IN = (IW == 0) ? 1 : IW;
    localparam int unsigned OW    = IW + SPLIT_LOG;

    logic                 up_vld;
    logic [NIN-1:0]       up_any;
    logic [NIN*IW_IN-1:0] up_idx;
    logic                 dn_vld;
    logic [NOUT-1:0]      dn_any;
    logic [NOUT*OW-1:0]   dn_idx;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
    logic [NIN-1:0]       up_err;
    logic [NOUT-1:0]      dn_err;
`endif

    if (k == 0) begin : g_leaf
      assign up_vld = s_vld;
      assign up_any = s_oht;
      assign up_idx = '0;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      assign up_err = '0;
`endif
    end else begin : g_node
      assign up_vld = g_lvl[k-1].dn_vld;
      assign up_any = g_lvl[k-1].dn_any;
      assign up_idx = g_lvl[k-1].dn_idx;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      assign up_err = g_lvl[k-1].dn_err;
`endif
    end

    oht2bin_pipe_stage #(
      .NODES_IN (NIN),
      .SPLIT    (SPLIT),
      .IDX_W    (IW)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (up_vld),
      .up_any (up_any),
      .up_idx (up_idx),
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
      .up_err (up_err),
      .dn_err (dn_err),
`endif
      .dn_rdy (rdy[k+1]),
      .dn_vld (dn_vld),
      .dn_any (dn_any),
      .dn_idx (dn_idx)
    );

    assign stage_vld[k] = dn_vld;
  end

  assign m_vld = g_lvl[LEVELS-1].dn_vld;
  assign m_any = g_lvl[LEVELS-1].dn_any[0];
  assign m_bin = g_lvl[LEVELS-1].dn_idx;
`ifdef OHT2BIN_PIPE_TREE_ERR_EN
  assign m_err = g_lvl[LEVELS-1].dn_err[0];
`else
  assign m_err = 1'b0;
`endif

endmodule
